// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from NREQ requesters into a single UART transmitter.
// Guards each write with a busy-acknowledge timeout and counts completed bytes.
module uart_tx_scheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_enable,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_wr,
  output logic                      tx_en,
  input  logic                      tx_busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      active,
  output logic                      err_timeout,
  input  logic                      err_clr,
  output logic [15:0]               bytes_sent
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] AckMax = CntW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              tx_en_q, tx_en_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic [15:0]       bytes_sent_q, bytes_sent_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              win_found;
  logic [IdW-1:0]    win_idx;
  logic [IdW-1:0]    cand;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdW'((32'(grant_id_q) + i) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    tx_data_d    = tx_data_q;
    tx_wr_d      = tx_wr_q;
    tx_en_d      = tx_en_q;
    grant_id_d   = grant_id_q;
    err_d        = err_q;
    bytes_sent_d = bytes_sent_q;
    cnt_d        = cnt_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_enable && !tx_busy && win_found) begin
          state_d     = StIssue;
          tx_data_d   = req_data[8*win_idx +: 8];
          grant_id_d  = win_idx;
          req_ready_d = NREQ'(1) << win_idx;
          tx_wr_d     = 1'b1;
          tx_en_d     = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
        cnt_d   = '0;
      end
      StWaitBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == AckMax) begin
          // Timeout set is applied after the clear so a same-cycle set wins.
          err_d   = 1'b1;
          tx_wr_d = 1'b0;
          tx_en_d = 1'b0;
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d      = StIdle;
          bytes_sent_d = bytes_sent_q + 16'd1;
          tx_wr_d      = 1'b0;
          tx_en_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_ready_q  <= '0;
      tx_data_q    <= 8'h00;
      tx_wr_q      <= 1'b0;
      tx_en_q      <= 1'b0;
      grant_id_q   <= IdW'(NREQ - 1);
      active_q     <= 1'b0;
      err_q        <= 1'b0;
      bytes_sent_q <= 16'h0000;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      tx_en_q      <= tx_en_d;
      grant_id_q   <= grant_id_d;
      active_q     <= active_d;
      err_q        <= err_d;
      bytes_sent_q <= bytes_sent_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_wr       = tx_wr_q;
  assign tx_en       = tx_en_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign err_timeout = err_q;
  assign bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a simple busy-handshake
// transmitter model; outputs are sampled on the falling clock edge.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;
  logic        err_clr;
  logic [15:0] bytes_sent;

  int n_cmp = 0;
  int n_bad = 0;

  int busy_delay = 2;
  int busy_hold  = 100;
  bit model_on   = 1'b1;

  int         pulses = 0;
  logic [1:0] gq[$];
  logic [7:0] dq[$];
  logic [3:0] rq[$];

  uart_tx_scheduler #(.NREQ(4), .ACK_TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_en       (tx_en),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .bytes_sent  (bytes_sent)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises busy_delay cycles after tx_wr and stays up busy_hold cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_on && tx_wr === 1'b1) begin
        repeat (busy_delay) @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_hold) @(negedge clk);
        tx_busy = 1'b0;
        while (tx_wr === 1'b1) @(negedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (req_ready !== 4'b0000) begin
      pulses++;
      gq.push_back(grant_id);
      dq.push_back(tx_data);
      rq.push_back(req_ready);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic wait_rise(input int bound, output bit ok, output int cyc);
    cyc = 0;
    while (tx_wr !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    ok = (tx_wr === 1'b1);
  endtask

  task automatic wait_fall(input int bound, output bit ok, output int cyc);
    cyc = 0;
    while (tx_wr !== 1'b0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    ok = (tx_wr === 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_enable = 1'b1; req_valid = 4'b0000; req_data = 32'h0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if ({tx_wr, tx_en} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_en: got %b want 00", {tx_wr, tx_en}); end
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_cmp++; if (bytes_sent !== 16'h0) begin n_bad++; $display("FAIL reset_bytes: got %h want 0000", bytes_sent); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    bit stable;
    int p0;
    p0 = pulses;
    busy_hold = 100;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    wait_rise(10, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_rise: got no tx_wr want tx_wr=1"); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", tx_data); end
    n_cmp++; if ({tx_en, active, grant_id} !== 4'b1100) begin n_bad++; $display("FAIL single_flags: got %b want 1100", {tx_en, active, grant_id}); end
    // Requester withdraws right after its acknowledge; the byte must still go out.
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    stable = 1'b1;
    cyc = 0;
    while (tx_wr !== 1'b0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (tx_wr === 1'b1 && tx_data !== 8'hA5) stable = 1'b0;
    end
    n_cmp++; if (cyc !== 102) begin n_bad++; $display("FAIL single_duration: got %0d want 102", cyc); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL single_data_stable: got unstable want stable"); end
    n_cmp++; if (bytes_sent !== 16'd1) begin n_bad++; $display("FAIL single_bytes: got %0d want 1", bytes_sent); end
    n_cmp++; if ({tx_wr, tx_en, active} !== 3'b000) begin n_bad++; $display("FAIL single_idle: got %b want 000", {tx_wr, tx_en, active}); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int cyc;
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;
    do_reset();
    busy_hold = 3;
    gq.delete(); dq.delete(); rq.delete();
    req_data = 32'h4332_2110;
    req_valid = 4'b1111;
    cyc = 0;
    while (gq.size() < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 4'b0000;
    wait_fall(50, ok, cyc);
    repeat (3) @(negedge clk);
    n_cmp++; if (gq.size() !== 8) begin n_bad++; $display("FAIL rr_count: got %0d want 8", gq.size()); end
    for (int k = 0; k < 8 && k < gq.size(); k++) begin
      n_cmp++; if (gq[k] !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gq[k], k % 4); end
      n_cmp++; if (dq[k] !== exp_data[k % 4]) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, dq[k], exp_data[k % 4]); end
      n_cmp++; if (rq[k] !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, rq[k], 4'(1 << (k % 4))); end
    end
    n_cmp++; if (bytes_sent !== 16'd8) begin n_bad++; $display("FAIL rr_bytes: got %0d want 8", bytes_sent); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    model_on = 1'b0;
    req_data = 32'h0000_005A;
    for (int pass = 0; pass < 2; pass++) begin
      // Second pass holds err_clr high: the timeout set must still win.
      err_clr = (pass == 1);
      req_valid = 4'b0001;
      wait_rise(10, ok, cyc);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_rise[%0d]: got no tx_wr want tx_wr=1", pass); end
      req_valid = 4'b0000;
      cyc = 0;
      while (err_timeout !== 1'b1 && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      // One ISSUE cycle plus 256 WAIT_BUSY cycles (counter 0..255).
      n_cmp++; if (cyc !== 257) begin n_bad++; $display("FAIL to_latency[%0d]: got %0d want 257", pass, cyc); end
      n_cmp++; if ({tx_wr, tx_en, active} !== 3'b000) begin n_bad++; $display("FAIL to_idle[%0d]: got %b want 000", pass, {tx_wr, tx_en, active}); end
      n_cmp++; if (bytes_sent !== 16'd8) begin n_bad++; $display("FAIL to_bytes[%0d]: got %0d want 8", pass, bytes_sent); end
      if (pass == 0) begin
        repeat (3) @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        err_clr = 1'b1;
      end
      @(negedge clk);
      err_clr = 1'b0;
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear[%0d]: got %b want 0", pass, err_timeout); end
    end
    model_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    int p0;
    busy_hold = 50;
    req_data = 32'h0000_7700;
    req_valid = 4'b0010;
    wait_rise(10, ok, cyc);
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rm_grant: got %0d want 1", grant_id); end
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({req_ready, tx_data} !== 12'h000) begin n_bad++; $display("FAIL rm_ready_data: got %h want 000", {req_ready, tx_data}); end
    n_cmp++; if ({tx_wr, tx_en, active, err_timeout} !== 4'b0000) begin n_bad++; $display("FAIL rm_flags: got %b want 0000", {tx_wr, tx_en, active, err_timeout}); end
    n_cmp++; if ({grant_id, bytes_sent} !== {2'd3, 16'h0}) begin n_bad++; $display("FAIL rm_gid_bytes: got %h want 30000", {grant_id, bytes_sent}); end
    req_valid = 4'b0000;
    p0 = pulses;
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++; if (pulses !== p0) begin n_bad++; $display("FAIL rm_no_repulse: got %0d want %0d", pulses, p0); end
    n_cmp++; if ({tx_wr, active} !== 2'b00) begin n_bad++; $display("FAIL rm_idle: got %b want 00", {tx_wr, active}); end
  endtask

  task automatic test_cfg_enable();
    bit ok;
    int cyc;
    int p0;
    busy_hold = 5;
    cfg_enable = 1'b1;
    req_data = 32'h4433_2211;
    p0 = pulses;
    req_valid = 4'b1111;
    wait_rise(10, ok, cyc);
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL cfg_grant0: got %0d want 0", grant_id); end
    repeat (4) @(negedge clk);
    cfg_enable = 1'b0;
    wait_fall(50, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cfg_complete: got tx_wr stuck want tx_wr=0"); end
    repeat (20) @(negedge clk);
    n_cmp++; if (bytes_sent !== 16'd1) begin n_bad++; $display("FAIL cfg_bytes1: got %0d want 1", bytes_sent); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL cfg_blocked: got %0d grants want 1", pulses - p0); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL cfg_idle: got %b want 0", active); end
    cfg_enable = 1'b1;
    wait_rise(10, ok, cyc);
    n_cmp++; if ({ok, grant_id, tx_data} !== {1'b1, 2'd1, 8'h22}) begin n_bad++; $display("FAIL cfg_resume: got %h want 122", {ok, grant_id, tx_data}); end
    req_valid = 4'b0000;
    wait_fall(50, ok, cyc);
    @(negedge clk);
    n_cmp++; if (bytes_sent !== 16'd2) begin n_bad++; $display("FAIL cfg_bytes2: got %0d want 2", bytes_sent); end
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    logic [15:0] exp_bytes [2];
    exp_bytes[0] = 16'hFFFF; exp_bytes[1] = 16'h0000;
    busy_hold = 3;
    // Stands in for 65534 prior transfers, which would exceed the cycle budget.
    @(negedge clk);
    force dut.bytes_sent_q = 16'hFFFE;
    @(negedge clk);
    release dut.bytes_sent_q;
    @(negedge clk);
    req_data = 32'h0000_00C3;
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b0001;
      wait_rise(10, ok, cyc);
      req_valid = 4'b0000;
      wait_fall(50, ok, cyc);
      @(negedge clk);
      n_cmp++; if (bytes_sent !== exp_bytes[t]) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", t, bytes_sent, exp_bytes[t]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_cfg_enable();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
